// File: rtl/jtpopeye_prog_sched.sv
// jtpopeye_prog_sched
//   Download write scheduler. ROM bytes from the ioctl stream are paired into
//   16-bit word writes, queued in a small FIFO and issued to the SDRAM
//   programming port over a req/ack handshake. PROM-region bytes bypass the
//   FIFO and go straight to the PROM loader. dwn_done reports a fully drained
//   download.
module jtpopeye_prog_sched #(
    parameter int FIFO_AW   = 3,
    parameter int PROM_ADDR = 65536
) (
    input  logic        clk_rom,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [20:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_req,
    input  logic        prog_ack,
    output logic [12:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic        prom_wr,
    output logic        dwn_done,
    output logic        overflow
);

    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [21:0]      PROM_START = 22'(PROM_ADDR);
    localparam logic [FIFO_AW:0] FULL_CNT   = (FIFO_AW + 1)'(DEPTH);

    // One queued SDRAM write: word address, {odd, even} data, active-low lanes
    typedef struct packed {
        logic [20:0] addr;
        logic [15:0] data;
        logic [1:0]  mask;
    } word_t;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic               dl_q;

    logic               pend_valid_q, pend_valid_d;
    logic [20:0]        pend_addr_q,  pend_addr_d;
    logic [7:0]         pend_byte_q,  pend_byte_d;
    logic               flush_pend_q, flush_pend_d;

    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q,  count_d;
    word_t              mem [DEPTH];

    logic               overflow_q, overflow_d;

    state_t             state_q;
    word_t              out_q;
    logic               req_q;

    logic [12:0]        prom_addr_q;
    logic [7:0]         prom_data_q;
    logic               prom_wr_q;

    logic               done_q;

    logic               rom_wr;
    logic               prom_sel;
    logic               dl_rise;
    logic               dl_fall;
    logic               flush_req;
    logic               push;
    logic               push_ok;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [20:0]        wr_word_addr;
    word_t              push_word;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    assign wr_word_addr = ioctl_addr[21:1];
    assign rom_wr       = ioctl_wr && (ioctl_addr < PROM_START);
    assign prom_sel     = ioctl_wr && !(ioctl_addr < PROM_START);

    assign dl_rise      = !dl_q && downloading;
    assign dl_fall      = dl_q && !downloading;
    // A falling edge that coincides with a ROM byte is remembered and
    // applied on a later cycle so that only one word is pushed per cycle.
    assign flush_req    = dl_fall || flush_pend_q;

    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign push_ok      = push && !fifo_full;
    assign pop          = (state_q == S_REQ) && prog_ack;

    // Byte pairing: decide what (if anything) is pushed and how pend evolves
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_byte_d  = pend_byte_q;
        flush_pend_d = flush_req;
        push         = 1'b0;
        push_word    = '0;

        if (rom_wr) begin
            if (!ioctl_addr[0]) begin
                // Even byte: retire any older even byte alone, then hold this one
                if (pend_valid_q) begin
                    push      = 1'b1;
                    push_word = '{addr: pend_addr_q, data: {8'h00, pend_byte_q}, mask: 2'b10};
                end
                pend_valid_d = 1'b1;
                pend_addr_d  = wr_word_addr;
                pend_byte_d  = ioctl_data;
            end else if (pend_valid_q && (pend_addr_q == wr_word_addr)) begin
                // Odd byte completing the held even byte
                push         = 1'b1;
                push_word    = '{addr: wr_word_addr, data: {ioctl_data, pend_byte_q}, mask: 2'b00};
                pend_valid_d = 1'b0;
            end else begin
                // Stray odd byte: written alone, held even byte kept
                push      = 1'b1;
                push_word = '{addr: wr_word_addr, data: {ioctl_data, 8'h00}, mask: 2'b01};
            end
        end else if (flush_req) begin
            // End of download: the last even byte has no partner coming
            flush_pend_d = 1'b0;
            if (pend_valid_q) begin
                push         = 1'b1;
                push_word    = '{addr: pend_addr_q, data: {8'h00, pend_byte_q}, mask: 2'b10};
                pend_valid_d = 1'b0;
            end
        end

        if (dl_rise) begin
            flush_pend_d = 1'b0;
        end
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sticky overflow: cleared by a new download, set by any dropped word
    always_comb begin
        overflow_d = overflow_q;
        if (dl_rise) begin
            overflow_d = 1'b0;
        end
        if (push && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Pairing state, FIFO control and status flags
    always_ff @(posedge clk_rom) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (rst) begin
            dl_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_byte_q  <= '0;
            flush_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            dl_q         <= downloading;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_byte_q  <= pend_byte_d;
            flush_pend_q <= flush_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk_rom) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // count decide which entries are valid, so clearing it buys nothing.
        if (push_ok) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    // Request FSM: present the FIFO head and hold it until acknowledged
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        out_q   <= mem[rd_ptr_q];
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (prog_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // PROM byte path: register address/data and pulse the write for one cycle
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            prom_addr_q <= '0;
            prom_data_q <= '0;
            prom_wr_q   <= 1'b0;
        end else begin
            prom_wr_q <= prom_sel;
            if (prom_sel) begin
                prom_addr_q <= ioctl_addr[12:0];
                prom_data_q <= ioctl_data;
            end
        end
    end

    // Download-complete flag, one cycle behind the conditions it watches
    always_ff @(posedge clk_rom) begin
        if (rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= !downloading && !pend_valid_q && fifo_empty && (state_q == S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign prog_addr = out_q.addr;
    assign prog_data = out_q.data;
    assign prog_mask = out_q.mask;
    assign prog_req  = req_q;
    assign prom_addr = prom_addr_q;
    assign prom_data = prom_data_q;
    assign prom_wr   = prom_wr_q;
    assign dwn_done  = done_q;
    assign overflow  = overflow_q;

endmodule
